// File: rtl/washroom_input_conditioner.sv
// Synchronizes and debounces the raw washroom buttons, doors and float switch into clean levels and event pulses.
// Define WASHROOM_FLUSH_LOCKOUT_EN to suppress flush pulses that re-trigger within LOCKOUT_CYCLES of the previous one.
module washroom_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int WATER_CYCLES    = 64,
   parameter int LOCKOUT_CYCLES  = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic flush_in_raw,
   input  logic flush_out_raw,
   input  logic door_open_inside_raw,
   input  logic door_open_outside_raw,
   input  logic water_level_raw,
   output logic flush_in,
   output logic flush_out,
   output logic door_open_inside,
   output logic door_open_outside,
   output logic water_level,
   output logic flush_in_pulse,
   output logic flush_out_pulse,
   output logic door_event,
   output logic door_conflict
);

   localparam int NCH = 5;

   logic [NCH-1:0] raw;
   logic [NCH-1:0] stable;
   logic [NCH-1:0] stable_d;
   logic [NCH-1:0] rise;
   logic           flush_in_fire;
   logic           flush_out_fire;

   // Channel order: 0 flush_in, 1 flush_out, 2 door inside, 3 door outside, 4 water level.
   assign raw = {water_level_raw, door_open_outside_raw, door_open_inside_raw,
                 flush_out_raw, flush_in_raw};

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      localparam int N  = (i == NCH - 1) ? WATER_CYCLES : DEBOUNCE_CYCLES;
      localparam int CW = $clog2(N);
      localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

      logic          s1;
      logic          s2;
      logic          stable_q;
      logic [CW-1:0] cnt;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
         end else begin
            s1 <= raw[i];
            s2 <= s1;
            if (s2 == stable_q) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               stable_q <= s2;
               cnt      <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end

      assign stable[i] = stable_q;
   end

   assign flush_in          = stable[0];
   assign flush_out         = stable[1];
   assign door_open_inside  = stable[2];
   assign door_open_outside = stable[3];
   assign water_level       = stable[4];

   assign rise = stable & ~stable_d;

`ifdef WASHROOM_FLUSH_LOCKOUT_EN
   localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

   logic [LW-1:0] lock_in;
   logic [LW-1:0] lock_out;

   // A rising edge seen while the counter is still running is dropped, never queued.
   assign flush_in_fire  = rise[0] && (lock_in == '0);
   assign flush_out_fire = rise[1] && (lock_out == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_in  <= '0;
         lock_out <= '0;
      end else begin
         if (flush_in_fire)
            lock_in <= LW'(LOCKOUT_CYCLES);
         else if (lock_in != '0)
            lock_in <= lock_in - LW'(1);
         if (flush_out_fire)
            lock_out <= LW'(LOCKOUT_CYCLES);
         else if (lock_out != '0)
            lock_out <= lock_out - LW'(1);
      end
   end
`else
   assign flush_in_fire  = rise[0];
   assign flush_out_fire = rise[1];

   if (LOCKOUT_CYCLES < 0) begin : g_lockout_range_unused
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_d        <= '0;
         flush_in_pulse  <= 1'b0;
         flush_out_pulse <= 1'b0;
         door_event      <= 1'b0;
         door_conflict   <= 1'b0;
      end else begin
         stable_d        <= stable;
         flush_in_pulse  <= flush_in_fire;
         flush_out_pulse <= flush_out_fire;
         door_event      <= rise[2] | rise[3];
         door_conflict   <= stable[2] & stable[3];
      end
   end

endmodule

// File: tb/tb_washroom_input_conditioner.sv
// Bench for washroom_input_conditioner: directed timing checks plus random stimulus against a window-based model.
module tb_washroom_input_conditioner;

   localparam int DB = 4;
   localparam int WC = 64;
   localparam int LK = 32;
   localparam int HW = 72;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic flush_in_raw = 1'b0;
   logic flush_out_raw = 1'b0;
   logic door_open_inside_raw = 1'b0;
   logic door_open_outside_raw = 1'b0;
   logic water_level_raw = 1'b0;
   logic flush_in, flush_out, door_open_inside, door_open_outside, water_level;
   logic flush_in_pulse, flush_out_pulse, door_event, door_conflict;

   always #5 clk = ~clk;

   washroom_input_conditioner #(
      .DEBOUNCE_CYCLES(DB),
      .WATER_CYCLES   (WC),
      .LOCKOUT_CYCLES (LK)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .flush_in_raw         (flush_in_raw),
      .flush_out_raw        (flush_out_raw),
      .door_open_inside_raw (door_open_inside_raw),
      .door_open_outside_raw(door_open_outside_raw),
      .water_level_raw      (water_level_raw),
      .flush_in             (flush_in),
      .flush_out            (flush_out),
      .door_open_inside     (door_open_inside),
      .door_open_outside    (door_open_outside),
      .water_level          (water_level),
      .flush_in_pulse       (flush_in_pulse),
      .flush_out_pulse      (flush_out_pulse),
      .door_event           (door_event),
      .door_conflict        (door_conflict)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a channel's clean level flips once the last N synchronized
   // samples (raw taken 2..N+1 edges ago) all disagree with it.
   logic [HW-1:0] hist_m [5];
   logic [4:0]    st_m, st_d_m;
   logic          fi_p_m, fo_p_m, dev_m, dcf_m;
   int            lock_in_m, lock_out_m;
   logic [4:0]    raw_v;

   assign raw_v = {water_level_raw, door_open_outside_raw, door_open_inside_raw,
                   flush_out_raw, flush_in_raw};

   function automatic logic flips(input logic [HW-1:0] h, input int n, input logic cur);
      logic [HW-1:0] mask;
      logic [HW-1:0] win;
      mask = (HW'(1) << n) - HW'(1);
      win  = (h >> 1) & mask;
      return cur ? (win == '0) : (win == mask);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < 5; c++) hist_m[c] <= '0;
         st_m       <= '0;
         st_d_m     <= '0;
         fi_p_m     <= 1'b0;
         fo_p_m     <= 1'b0;
         dev_m      <= 1'b0;
         dcf_m      <= 1'b0;
         lock_in_m  <= 0;
         lock_out_m <= 0;
      end else begin
         for (int c = 0; c < 5; c++) begin
            hist_m[c] <= {hist_m[c][HW-2:0], raw_v[c]};
            if (flips(hist_m[c], (c == 4) ? WC : DB, st_m[c])) st_m[c] <= ~st_m[c];
         end
         st_d_m <= st_m;
         dev_m  <= (st_m[2] & ~st_d_m[2]) | (st_m[3] & ~st_d_m[3]);
         dcf_m  <= st_m[2] & st_m[3];
`ifdef WASHROOM_FLUSH_LOCKOUT_EN
         fi_p_m <= st_m[0] & ~st_d_m[0] & (lock_in_m == 0);
         fo_p_m <= st_m[1] & ~st_d_m[1] & (lock_out_m == 0);
         if (st_m[0] & ~st_d_m[0] & (lock_in_m == 0)) lock_in_m <= LK;
         else if (lock_in_m > 0) lock_in_m <= lock_in_m - 1;
         if (st_m[1] & ~st_d_m[1] & (lock_out_m == 0)) lock_out_m <= LK;
         else if (lock_out_m > 0) lock_out_m <= lock_out_m - 1;
`else
         fi_p_m <= st_m[0] & ~st_d_m[0];
         fo_p_m <= st_m[1] & ~st_d_m[1];
`endif
      end
   end

   function automatic logic [8:0] outs();
      return {water_level, door_open_outside, door_open_inside, flush_out, flush_in,
              flush_in_pulse, flush_out_pulse, door_event, door_conflict};
   endfunction

   function automatic logic [8:0] model_outs();
      return {st_m, fi_p_m, fo_p_m, dev_m, dcf_m};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("model", 32'(outs()), 32'(model_outs()));
      end
   endtask

   task automatic set_raw(input logic [4:0] r);
      flush_in_raw          = r[0];
      flush_out_raw         = r[1];
      door_open_inside_raw  = r[2];
      door_open_outside_raw = r[3];
      water_level_raw       = r[4];
   endtask

   task automatic do_reset(input logic [4:0] r);
      @(negedge clk);
      rst = 1'b1;
      set_raw(r);
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("outs_in_reset", 32'(outs()), 32'(0));
      end
      rst = 1'b0;
   endtask

   logic seen_fi, seen_wl;
   int   pulses_fi;

   task automatic track(input int n);
      for (int i = 0; i < n; i++) begin
         step(1);
         seen_fi   = seen_fi | flush_in;
         seen_wl   = seen_wl | water_level;
         pulses_fi = pulses_fi + int'(flush_in_pulse);
      end
   endtask

   task automatic clear_track();
      seen_fi   = 1'b0;
      seen_wl   = 1'b0;
      pulses_fi = 0;
   endtask

   function automatic logic probe(input int sel);
      case (sel)
         0:       return flush_in;
         1:       return water_level;
         default: return door_conflict;
      endcase
   endfunction

   // Edges from the current negedge until the probed output reaches 'want'.
   task automatic wait_edges(input string name, input int sel, input logic want,
                             input int bound, input int exp);
      int e;
      e = 0;
      do begin
         step(1);
         e++;
      end while (probe(sel) !== want && e < bound);
      check(name, 32'(e), 32'(exp));
   endtask

   typedef struct {
      string name;
      int    width;
      logic  exp_level;
      int    exp_pulses;
   } glitch_vec_t;

   glitch_vec_t gv [5];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      gv[0] = '{"glitch_w1", 1, 1'b0, 0};
      gv[1] = '{"glitch_w3", 3, 1'b0, 0};
      gv[2] = '{"glitch_w4", 4, 1'b1, 1};
      gv[3] = '{"glitch_w6", 6, 1'b1, 1};
      gv[4] = '{"glitch_w2", 2, 1'b0, 0};

      #1 rst = 1'b1;

      // Reset release with every raw input held high.
      do_reset(5'b11111);
      step(5);
      check("flush_in_edge5", 32'(flush_in), 32'(0));
      step(1);
      check("buttons_edge6", 32'({flush_in, flush_out, door_open_inside, door_open_outside}), 32'(4'hf));
      check("pulse_edge6", 32'(flush_in_pulse), 32'(0));
      check("water_edge6", 32'(water_level), 32'(0));
      step(1);
      check("pulses_edge7", 32'({flush_in_pulse, flush_out_pulse, door_event, door_conflict}), 32'(4'hf));
      step(1);
      check("pulses_edge8", 32'({flush_in_pulse, flush_out_pulse, door_event, door_conflict}), 32'(4'h1));

      door_open_inside_raw = 1'b0;
      wait_edges("conflict_clear", 2, 1'b0, 30, DB + 3);

      // Glitch widths around the debounce threshold.
      for (int i = 0; i < 5; i++) begin
         do_reset(5'b00000);
         clear_track();
         flush_in_raw = 1'b1;
         track(gv[i].width);
         flush_in_raw = 1'b0;
         track(20);
         check({gv[i].name, "_level"}, 32'(seen_fi), 32'(gv[i].exp_level));
         check({gv[i].name, "_pulses"}, 32'(pulses_fi), 32'(gv[i].exp_pulses));
      end

      // Float switch sloshing every 20 cycles, then held.
      do_reset(5'b00000);
      clear_track();
      for (int k = 0; k < 10; k++) begin
         water_level_raw = (k % 2 == 0);
         track(20);
      end
      water_level_raw = 1'b0;
      track(5);
      check("water_slosh", 32'(seen_wl), 32'(0));
      water_level_raw = 1'b1;
      wait_edges("water_latency", 1, 1'b1, 120, WC + 2);

      // Flush lockout: clean rising edges 10 apart, then 40 apart.
      do_reset(5'b00000);
      clear_track();
      flush_in_raw = 1'b1; track(5);
      flush_in_raw = 1'b0; track(5);
      flush_in_raw = 1'b1; track(5);
      flush_in_raw = 1'b0; track(40);
`ifdef WASHROOM_FLUSH_LOCKOUT_EN
      check("lockout_10", 32'(pulses_fi), 32'(1));
`else
      check("lockout_10", 32'(pulses_fi), 32'(2));
`endif
      clear_track();
      flush_in_raw = 1'b1; track(5);
      flush_in_raw = 1'b0; track(35);
      flush_in_raw = 1'b1; track(5);
      flush_in_raw = 1'b0; track(40);
      check("lockout_40", 32'(pulses_fi), 32'(2));

      // Asynchronous reset after two mismatch cycles.
      do_reset(5'b00000);
      flush_in_raw = 1'b1;
      step(4);
      #2 rst = 1'b1;
      #1 check("async_reset_outs", 32'(outs()), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      wait_edges("restart_latency", 0, 1'b1, 30, DB + 2);

      // Random stimulus with one asynchronous reset in the middle.
      do_reset(5'b00000);
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if ($urandom_range(0, 5) == 0) flush_in_raw = ~flush_in_raw;
         if ($urandom_range(0, 5) == 0) flush_out_raw = ~flush_out_raw;
         if ($urandom_range(0, 5) == 0) door_open_inside_raw = ~door_open_inside_raw;
         if ($urandom_range(0, 5) == 0) door_open_outside_raw = ~door_open_outside_raw;
         if ($urandom_range(0, 60) == 0) water_level_raw = ~water_level_raw;
         if (cyc == 1000) begin
            #2 rst = 1'b1;
            #1 check("rand_async_reset", 32'(outs()), 32'(0));
            @(negedge clk);
            rst = 1'b0;
         end
         step(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
